// File: rtl/flp_adder_tree_if.sv
// flp_adder_tree_if: groups the ten input exponents and the float result
// of the pseudo-softmax denominator adder tree into one bundle.
// Optional feature macro: FLP_ADDER_TREE_VALID_EN adds in_valid/out_valid.
interface flp_adder_tree_if #(
  parameter int IN_W   = 8,
  parameter int EXP_W  = 9,
  parameter int MANT_W = 8
);
  logic [IN_W-1:0]   x1;
  logic [IN_W-1:0]   x2;
  logic [IN_W-1:0]   x3;
  logic [IN_W-1:0]   x4;
  logic [IN_W-1:0]   x5;
  logic [IN_W-1:0]   x6;
  logic [IN_W-1:0]   x7;
  logic [IN_W-1:0]   x8;
  logic [IN_W-1:0]   x9;
  logic [IN_W-1:0]   x10;
  logic [EXP_W-1:0]  exp;
  logic [MANT_W-1:0] mant;
`ifdef FLP_ADDER_TREE_VALID_EN
  logic              in_valid;
  logic              out_valid;

  modport master (
    output x1, x2, x3, x4, x5, x6, x7, x8, x9, x10, in_valid,
    input  exp, mant, out_valid
  );
  modport slave (
    input  x1, x2, x3, x4, x5, x6, x7, x8, x9, x10, in_valid,
    output exp, mant, out_valid
  );
`else
  modport master (
    output x1, x2, x3, x4, x5, x6, x7, x8, x9, x10,
    input  exp, mant
  );
  modport slave (
    input  x1, x2, x3, x4, x5, x6, x7, x8, x9, x10,
    output exp, mant
  );
`endif
endinterface

// File: rtl/flp_adder_tree.sv
// flp_adder_tree: four-stage pipelined floating-point adder tree.
// Each input x_i stands for 2^x_i; the output is the sum of all ten terms
// as 1.mant x 2^exp, with truncation at every add in a fixed tree order.
// Optional feature macro: FLP_ADDER_TREE_VALID_EN (valid shift register).
// EXP_W must be at least IN_W+1 so the growth of up to three binades fits.
module flp_adder_tree #(
  parameter int IN_W   = 8,
  parameter int EXP_W  = 9,
  parameter int MANT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  flp_adder_tree_if.slave   bus
);

  localparam int FLT_W = EXP_W + MANT_W;
  // Alignment distance at which the smaller significand is entirely shifted out.
  localparam logic [EXP_W-1:0] SIG_W_E = EXP_W'(MANT_W + 1);

  // Add two floats {e, f}; result truncated, never below the larger operand.
  function automatic logic [FLT_W-1:0] fp_add(
    input logic [FLT_W-1:0] a,
    input logic [FLT_W-1:0] b
  );
    logic [EXP_W-1:0]  e_hi;
    logic [EXP_W-1:0]  e_lo;
    logic [EXP_W-1:0]  d;
    logic [MANT_W-1:0] f_hi;
    logic [MANT_W-1:0] f_lo;
    logic [MANT_W:0]   sig_lo_sh;
    logic [MANT_W+1:0] sum;
    logic [EXP_W-1:0]  e_out;
    logic [MANT_W-1:0] f_out;
    if (a[FLT_W-1:MANT_W] >= b[FLT_W-1:MANT_W]) begin
      e_hi = a[FLT_W-1:MANT_W];
      f_hi = a[MANT_W-1:0];
      e_lo = b[FLT_W-1:MANT_W];
      f_lo = b[MANT_W-1:0];
    end else begin
      e_hi = b[FLT_W-1:MANT_W];
      f_hi = b[MANT_W-1:0];
      e_lo = a[FLT_W-1:MANT_W];
      f_lo = a[MANT_W-1:0];
    end
    d = e_hi - e_lo;
    if (d >= SIG_W_E) begin
      sig_lo_sh = '0;
    end else begin
      sig_lo_sh = {1'b1, f_lo} >> d;
    end
    sum = {1'b0, 1'b1, f_hi} + {1'b0, sig_lo_sh};
    // A carry into bit MANT_W+1 means the sum reached [2,4): renormalise by one.
    if (sum[MANT_W+1]) begin
      e_out = e_hi + EXP_W'(1);
      f_out = sum[MANT_W:1];
    end else begin
      e_out = e_hi;
      f_out = sum[MANT_W-1:0];
    end
    return {e_out, f_out};
  endfunction

  logic [FLT_W-1:0] leaf_s [10];

  logic [FLT_W-1:0] l1_r [5];
  logic [FLT_W-1:0] l2_a_r;
  logic [FLT_W-1:0] l2_b_r;
  logic [FLT_W-1:0] l2_s910_r;
  logic [FLT_W-1:0] l3_c_r;
  logic [FLT_W-1:0] l3_s910_r;
  logic [FLT_W-1:0] l4_r;

  // Leaf conversion: each exponent becomes 1.0 x 2^x_i.
  always_comb begin
    leaf_s[0] = {EXP_W'(bus.x1),  {MANT_W{1'b0}}};
    leaf_s[1] = {EXP_W'(bus.x2),  {MANT_W{1'b0}}};
    leaf_s[2] = {EXP_W'(bus.x3),  {MANT_W{1'b0}}};
    leaf_s[3] = {EXP_W'(bus.x4),  {MANT_W{1'b0}}};
    leaf_s[4] = {EXP_W'(bus.x5),  {MANT_W{1'b0}}};
    leaf_s[5] = {EXP_W'(bus.x6),  {MANT_W{1'b0}}};
    leaf_s[6] = {EXP_W'(bus.x7),  {MANT_W{1'b0}}};
    leaf_s[7] = {EXP_W'(bus.x8),  {MANT_W{1'b0}}};
    leaf_s[8] = {EXP_W'(bus.x9),  {MANT_W{1'b0}}};
    leaf_s[9] = {EXP_W'(bus.x10), {MANT_W{1'b0}}};
  end

  // Level 1: five pairwise sums of adjacent leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        l1_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        l1_r[i] <= fp_add(leaf_s[2*i], leaf_s[2*i+1]);
      end
    end
  end

  // Level 2: combine pairs of level-1 sums; s910 waits one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l2_a_r    <= '0;
      l2_b_r    <= '0;
      l2_s910_r <= '0;
    end else begin
      l2_a_r    <= fp_add(l1_r[0], l1_r[1]);
      l2_b_r    <= fp_add(l1_r[2], l1_r[3]);
      l2_s910_r <= l1_r[4];
    end
  end

  // Level 3: combine the two level-2 sums; s910 waits another stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l3_c_r    <= '0;
      l3_s910_r <= '0;
    end else begin
      l3_c_r    <= fp_add(l2_a_r, l2_b_r);
      l3_s910_r <= l2_s910_r;
    end
  end

  // Level 4: final add of the eight-term sum with the s910 pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l4_r <= '0;
    end else begin
      l4_r <= fp_add(l3_c_r, l3_s910_r);
    end
  end

  assign bus.exp  = l4_r[FLT_W-1:MANT_W];
  assign bus.mant = l4_r[MANT_W-1:0];

`ifdef FLP_ADDER_TREE_VALID_EN
  logic [3:0] vld_r;

  // Valid tag travels alongside the data through the four stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= 4'b0000;
    end else begin
      vld_r <= {vld_r[2:0], bus.in_valid};
    end
  end

  assign bus.out_valid = vld_r[3];
`endif

endmodule

// File: tb/tb_flp_adder_tree.sv
// tb_flp_adder_tree: directed vector table, hand-written pipeline/reset
// sequences and a randomized stream checked against a value-level model.
module tb_flp_adder_tree;

  logic clk;
  logic rst_n;

  flp_adder_tree_if bus ();

  flp_adder_tree dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string            name;
    logic [9:0][7:0]  x;
    logic [8:0]       e;
    logic [7:0]       m;
  } vec_t;

  typedef struct {
    logic [8:0] e;
    logic [7:0] m;
    logic       v;
  } exp_t;

  // Reference add on values: a float is sig * 2^(e-8) with sig in [256,512).
  // The smaller term is reduced to whole units of the larger term's last
  // fraction bit (anything finer is lost), then the total is renormalised
  // with the dropped half-unit also lost.
  function automatic void ref_add(input int ea, input int fa, input int eb, input int fb,
                                  output int er, output int fr);
    int big_e, big_sig, small_sig, gap, units;
    if (ea >= eb) begin
      big_e = ea; big_sig = 256 + fa; small_sig = 256 + fb; gap = ea - eb;
    end else begin
      big_e = eb; big_sig = 256 + fb; small_sig = 256 + fa; gap = eb - ea;
    end
    units = big_sig + ((gap > 20) ? 0 : (small_sig / (1 << gap)));
    if (units >= 512) begin
      er = big_e + 1; fr = units / 2 - 256;
    end else begin
      er = big_e;     fr = units - 256;
    end
  endfunction

  // Reference tree: ((x1+x2)+(x3+x4)) + ((x5+x6)+(x7+x8)), then + (x9+x10).
  function automatic void ref_sum(input logic [9:0][7:0] x, output int e, output int f);
    int pe[5], pf[5];
    int ae, af, be, bf, ce, cf;
    for (int i = 0; i < 5; i++) begin
      ref_add(int'(x[2*i]), 0, int'(x[2*i+1]), 0, pe[i], pf[i]);
    end
    ref_add(pe[0], pf[0], pe[1], pf[1], ae, af);
    ref_add(pe[2], pf[2], pe[3], pf[3], be, bf);
    ref_add(ae, af, be, bf, ce, cf);
    ref_add(ce, cf, pe[4], pf[4], e, f);
  endfunction

  task automatic set_x(input logic [9:0][7:0] v);
    bus.x1 = v[0]; bus.x2 = v[1]; bus.x3 = v[2]; bus.x4 = v[3]; bus.x5 = v[4];
    bus.x6 = v[5]; bus.x7 = v[6]; bus.x8 = v[7]; bus.x9 = v[8]; bus.x10 = v[9];
  endtask

  task automatic set_valid(input logic v);
`ifdef FLP_ADDER_TREE_VALID_EN
    bus.in_valid = v;
`else
    if (v) begin end
`endif
  endtask

  // One clock: through the rising edge, then settle at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [8:0] we, input logic [7:0] wm);
    checks++;
    if (bus.exp !== we || bus.mant !== wm) begin
      errors++;
      $display("FAIL %s: got exp=%0d mant=0x%02h, want exp=%0d mant=0x%02h",
               name, bus.exp, bus.mant, we, wm);
    end
  endtask

  task automatic chk_valid(input string name, input logic wv);
`ifdef FLP_ADDER_TREE_VALID_EN
    checks++;
    if (bus.out_valid !== wv) begin
      errors++;
      $display("FAIL %s: got out_valid=%0b, want %0b", name, bus.out_valid, wv);
    end
`else
    if (wv === 1'bx) begin end
    if (name.len() == 0) begin end
`endif
  endtask

  vec_t            tbl[5];
  logic [9:0][7:0] v;
  logic [9:0][7:0] zeros;
  logic [9:0][7:0] ramp;
  logic [9:0][7:0] all255;
  exp_t            q[$];
  exp_t            item;
  int              re, rf, base;

  initial begin
    for (int i = 0; i < 10; i++) begin
      zeros[i]  = 8'd0;
      ramp[i]   = 8'(i + 1);
      all255[i] = 8'd255;
    end
    tbl[0] = '{name: "all_zero",  x: zeros,  e: 9'd3,   m: 8'h40};
    tbl[1] = '{name: "ramp_1_10", x: ramp,   e: 9'd10,  m: 8'hFF};
    tbl[2] = '{name: "all_255",   x: all255, e: 9'd258, m: 8'h40};
    v = zeros; v[0] = 8'd200;
    tbl[3] = '{name: "x1_200",    x: v,      e: 9'd200, m: 8'h00};
    v = zeros; v[8] = 8'd4; v[9] = 8'd4;
    tbl[4] = '{name: "s910_only", x: v,      e: 9'd5,   m: 8'h40};

    // Reset state.
    rst_n = 1'b0;
    set_x(zeros);
    set_valid(1'b0);
    #1;
    chk("reset_state", 9'd0, 8'h00);
    chk_valid("reset_valid", 1'b0);
    step();
    step();
    rst_n = 1'b1;

    // Directed table, one vector at a time through the full latency.
    for (int i = 0; i < 5; i++) begin
      set_x(tbl[i].x);
      set_valid(1'b1);
      step();
      set_valid(1'b0);
      step(); step(); step();
      chk(tbl[i].name, tbl[i].e, tbl[i].m);
      chk_valid({tbl[i].name, "_valid"}, 1'b1);
    end

    // Back-to-back: three vectors on consecutive cycles, results on consecutive cycles.
    set_x(zeros);  set_valid(1'b1); step();
    set_x(ramp);   set_valid(1'b1); step();
    set_x(all255); set_valid(1'b0); step();
    set_x(zeros);  step();
    chk("b2b_first", 9'd3, 8'h40);
    chk_valid("b2b_first_valid", 1'b1);
    step();
    chk("b2b_second", 9'd10, 8'hFF);
    chk_valid("b2b_second_valid", 1'b1);
    step();
    chk("b2b_third", 9'd258, 8'h40);
    chk_valid("b2b_third_valid", 1'b0);

    // Randomized stream against the reference model.
    for (int i = 0; i < 300; i++) begin
      base = $urandom_range(0, 243);
      for (int k = 0; k < 10; k++) begin
        if ($urandom_range(0, 3) == 0) v[k] = 8'($urandom_range(0, 255));
        else                           v[k] = 8'(base + $urandom_range(0, 12));
      end
      ref_sum(v, re, rf);
      item.e = 9'(re);
      item.m = 8'(rf);
      item.v = 1'($urandom_range(0, 1));
      set_x(v);
      set_valid(item.v);
      q.push_back(item);
      step();
      if (q.size() == 4) begin
        item = q.pop_front();
        chk("random", item.e, item.m);
        chk_valid("random_valid", item.v);
      end
    end
    for (int i = 0; i < 3; i++) begin
      set_valid(1'b0);
      step();
      item = q.pop_front();
      chk("random_flush", item.e, item.m);
      chk_valid("random_flush_valid", item.v);
    end

    // Asynchronous reset in the middle of a cycle with data in flight.
    set_x(ramp);
    set_valid(1'b1);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 9'd0, 8'h00);
    chk_valid("async_reset_valid", 1'b0);
    step();
    chk("reset_held", 9'd0, 8'h00);
    set_x(zeros);
    set_valid(1'b1);
    rst_n = 1'b1;
    step();
    set_valid(1'b0);
    step(); step();
    checks++;
    if (bus.exp === 9'd3 && bus.mant === 8'h40) begin
      errors++;
      $display("FAIL post_reset_early: got exp=%0d mant=0x%02h after 3 edges, want not yet 3/0x40",
               bus.exp, bus.mant);
    end
    chk_valid("post_reset_early_valid", 1'b0);
    step();
    chk("post_reset_first", 9'd3, 8'h40);
    chk_valid("post_reset_first_valid", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
